mole_scheduler: RTL
===================

Name: mole_scheduler

Overview:
- Game sequencer for the whack-a-mole display path. Decides which of NUM_HOLES holes shows a mole, for how long, and when the game ends.
- Time base is frames. One frame_tick pulse arrives per VGA frame, derived from vsync upstream.
- Outputs drive the mole renderer (mole_active, mole_hole) and the score/lives display.
- Accepts registered hit reports from the button/switch front end.

Parameters:
- NUM_HOLES, 9, number of mole holes; legal range 2..16.
- UP_FRAMES, 60, frames a mole stays visible before counting as a miss.
- GAP_FRAMES, 30, blank frames between moles.
- LIVES, 3, misses allowed before game over; range 1..3.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  level/pulse; begins a game from IDLE or OVER.
- hit_valid  in  1  one-cycle pulse: player struck a hole.
- hit_hole  in  4  index of struck hole, valid with hit_valid.
- mole_active  out  1  mole currently visible.
- mole_hole  out  4  index of visible mole; 0..NUM_HOLES-1.
- score  out  SCORE_W  hits this game, saturating.
- lives  out  2  remaining lives.
- hit_ok  out  1  one-cycle pulse on a correct hit.
- game_over  out  1  high in OVER state.

Behaviour:
- Reset (reset==0 at a clk edge) takes effect at that edge, from any state, including mid-game:
  - state=IDLE, lfsr=LFSR_SEED, frame counter=0.
  - mole_active=0, mole_hole=0, score=0, lives=0, hit_ok=0, game_over=0.
- All outputs are registered.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances only on frame_tick and only in SHOW/GAP states.
- Hole pick: c = lfsr[3:0]; if c >= NUM_HOLES then c = c - NUM_HOLES; if c == mole_hole then c = (c+1) mod NUM_HOLES. Never repeats a hole back-to-back.
- States:
  - IDLE: all outputs at reset values. start==1 -> SHOW next cycle with score=0, lives=LIVES, hole picked from the current lfsr, counter=0.
  - SHOW: mole_active=1. Each frame_tick increments the counter.
    - Hit: hit_valid && hit_hole==mole_hole -> score+1 (saturates at all-ones), hit_ok=1 for exactly one cycle, counter=0, -> GAP. mole_active falls on the cycle after hit_valid.
    - Wrong hole: hit_valid with hit_hole!=mole_hole, including out-of-range indices, is ignored with no penalty.
    - Timeout: frame_tick while counter==UP_FRAMES-1 -> lives-1, counter=0. If the new lives==0 -> OVER, else -> GAP.
    - A correct hit and a timeout in the same cycle: the hit wins; no life is lost.
  - GAP: mole_active=0; hits ignored. frame_tick while counter==GAP_FRAMES-1 -> pick new hole, counter=0, -> SHOW.
  - OVER: game_over=1, mole_active=0; score and lives hold. start==1 -> restart exactly as from IDLE; game_over clears the same cycle mole_active rises.
- start is ignored in SHOW and GAP.
- frame_tick and hit_valid in the same cycle are both processed.
- mole_hole holds its last value while mole_active=0.

Test Plan:
- Apply reset low for 2 cycles mid-SHOW -> next cycle all outputs zero, state IDLE, lfsr=8'hA5; start then yields the same first hole as after power-up.
- Start, then do nothing for 60 frame_ticks -> lives 3->2 on the 60th tick edge, mole_active=0 for 30 ticks, then SHOW with a different mole_hole.
- Start, then 3 consecutive misses -> game_over=1 after the third timeout, lives=0, score=0; start -> lives=3, score=0, game_over=0.
- Start, then hit_valid with hit_hole=mole_hole on frame 10 -> hit_ok single-cycle pulse, score=1, mole_active=0 next cycle; wrong-hole hit -> score unchanged, mole stays.
- Hit coincident with the 60th frame_tick -> score+1, lives unchanged.
- With SCORE_W=2, make 5 correct hits -> score saturates at 3; across 100 moles, mole_hole is always < NUM_HOLES and never equals the previous hole.

Source files
------------

// File: rtl/mole_scheduler.sv
// -----------------------------------------------------------------------------
// mole_scheduler
//
// Game sequencer for the whack-a-mole display path. It decides which hole
// shows a mole, how long the mole stays up, and when the game ends. The time
// base is video frames: one frame_tick pulse arrives per frame.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   frame_tick   one-cycle pulse per video frame
//   start        begins a game from IDLE or OVER (ignored while playing)
//   hit_valid    one-cycle pulse: the player struck a hole
//   hit_hole     index of the struck hole, qualified by hit_valid
//   mole_active  a mole is currently visible
//   mole_hole    index of the visible mole (held while no mole is shown)
//   score        correct hits this game, saturating
//   lives        remaining lives
//   hit_ok       one-cycle pulse on a correct hit
//   game_over    high while in the OVER state
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mole_scheduler #(
    parameter int           NUM_HOLES  = 9,
    parameter int           UP_FRAMES  = 60,
    parameter int           GAP_FRAMES = 30,
    parameter int           LIVES      = 3,
    parameter logic [7:0]   LFSR_SEED  = 8'hA5,
    parameter int           SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               hit_valid,
    input  logic [3:0]         hit_hole,
    output logic               mole_active,
    output logic [3:0]         mole_hole,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               hit_ok,
    output logic               game_over
);

    // Frame counter must reach max(UP_FRAMES, GAP_FRAMES) - 1.
    localparam int CNT_MAX = (UP_FRAMES > GAP_FRAMES) ? UP_FRAMES : GAP_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] UP_LAST    = CNT_W'(UP_FRAMES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_FRAMES - 1);
    localparam logic [4:0]       NH         = 5'(NUM_HOLES);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t             state_reg;
    logic [7:0]         lfsr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               mole_active_reg;
    logic [3:0]         mole_hole_reg;
    logic [SCORE_W-1:0] score_reg;
    logic [1:0]         lives_reg;
    logic               hit_ok_reg;
    logic               game_over_reg;

    // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1, shifting left.
    logic       lfsr_fb;
    logic [7:0] lfsr_next;

    assign lfsr_fb   = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    assign lfsr_next = {lfsr_reg[6:0], lfsr_fb};

    // Hole pick from the current (pre-advance) LFSR value. A single
    // subtraction folds 0..15 into range whenever NUM_HOLES >= 8; the extra
    // modulo only matters for smaller boards and keeps the index legal there.
    // Bumping to the next hole on a match prevents back-to-back repeats.
    logic [4:0] pick_c;
    logic [3:0] pick_hole;

    always_comb begin
        pick_c = {1'b0, lfsr_reg[3:0]};
        if (pick_c >= NH) begin
            pick_c = pick_c - NH;
        end
        if (pick_c >= NH) begin
            pick_c = pick_c % NH;
        end
        if (pick_c[3:0] == mole_hole_reg) begin
            pick_c = pick_c + 5'd1;
            if (pick_c == NH) begin
                pick_c = 5'd0;
            end
        end
        pick_hole = pick_c[3:0];
    end

    logic hit_match;
    assign hit_match = hit_valid && (hit_hole == mole_hole_reg);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            lfsr_reg        <= LFSR_SEED;
            cnt_reg         <= '0;
            mole_active_reg <= 1'b0;
            mole_hole_reg   <= 4'd0;
            score_reg       <= '0;
            lives_reg       <= 2'd0;
            hit_ok_reg      <= 1'b0;
            game_over_reg   <= 1'b0;
        end else begin
            hit_ok_reg <= 1'b0;

            case (state_reg)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_reg       <= S_SHOW;
                        score_reg       <= '0;
                        lives_reg       <= LIVES_INIT;
                        mole_hole_reg   <= pick_hole;
                        cnt_reg         <= '0;
                        mole_active_reg <= 1'b1;
                        game_over_reg   <= 1'b0;
                    end
                end

                S_SHOW: begin
                    if (frame_tick) begin
                        lfsr_reg <= lfsr_next;
                    end
                    // A correct hit takes priority over a coincident timeout.
                    if (hit_match) begin
                        if (score_reg != '1) begin
                            score_reg <= score_reg + 1'b1;
                        end
                        hit_ok_reg      <= 1'b1;
                        cnt_reg         <= '0;
                        mole_active_reg <= 1'b0;
                        state_reg       <= S_GAP;
                    end else if (frame_tick) begin
                        if (cnt_reg == UP_LAST) begin
                            lives_reg       <= lives_reg - 2'd1;
                            cnt_reg         <= '0;
                            mole_active_reg <= 1'b0;
                            if (lives_reg == 2'd1) begin
                                state_reg     <= S_OVER;
                                game_over_reg <= 1'b1;
                            end else begin
                                state_reg <= S_GAP;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    if (frame_tick) begin
                        lfsr_reg <= lfsr_next;
                        if (cnt_reg == GAP_LAST) begin
                            mole_hole_reg   <= pick_hole;
                            cnt_reg         <= '0;
                            mole_active_reg <= 1'b1;
                            state_reg       <= S_SHOW;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign mole_active = mole_active_reg;
    assign mole_hole   = mole_hole_reg;
    assign score       = score_reg;
    assign lives       = lives_reg;
    assign hit_ok      = hit_ok_reg;
    assign game_over   = game_over_reg;

endmodule
